// File: rtl/eth_f_pkt_tx_shaper.sv
// Packet TX shaper: pops show-ahead generator words, checks SOP/EOP framing, enforces
// a programmable inter-packet gap and drives a valid/ready TX port through a 2-entry skid buffer.
module eth_f_pkt_tx_shaper #(
  parameter int DATA_BCNT = 8,
  parameter int CTRL_BCNT = 2,
  parameter int EMPTY_W   = 3,
  parameter int IPG_W     = 8,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   tx_pkt_req,
  input  logic                   tx_pkt_rdata_vld,
  input  logic [DATA_BCNT*8-1:0] tx_pkt_rdata,
  input  logic [CTRL_BCNT*8-1:0] tx_pkt_rdata_ctrl,
  input  logic                   cfg_tx_en,
  input  logic [IPG_W-1:0]       cfg_ipg_cycles,
  input  logic                   cfg_cnt_clr,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [DATA_BCNT*8-1:0] tx_data,
  output logic                   tx_sop,
  output logic                   tx_eop,
  output logic [EMPTY_W-1:0]     tx_empty,
  output logic [CNT_W-1:0]       stat_pkt_cnt,
  output logic [CNT_W-1:0]       stat_err_cnt,
  output logic                   busy
);

  localparam int DATA_W = DATA_BCNT * 8;
  localparam int CTRL_W = CTRL_BCNT * 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  logic [1:0]       state_q, state_d;
  logic [IPG_W-1:0] gap_q, gap_d;
  beat_t            skid_q [2];
  beat_t            skid_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic  state_allows;
  logic  pop;
  logic  push;
  logic  rd;
  logic  err_inc;
  beat_t in_beat;
  beat_t head;
  logic  ctrl_unused;

  assign in_beat.sop   = tx_pkt_rdata_ctrl[CTRL_W-1];
  assign in_beat.eop   = tx_pkt_rdata_ctrl[CTRL_W-2];
  assign in_beat.empty = tx_pkt_rdata_ctrl[EMPTY_W-1:0];
  assign in_beat.data  = tx_pkt_rdata;
  assign ctrl_unused   = ^tx_pkt_rdata_ctrl[CTRL_W-3:EMPTY_W];

  always_comb begin
    state_allows = 1'b0;
    case (state_q)
      ST_IDLE: state_allows = cfg_tx_en;
      ST_XFER: state_allows = 1'b1;
      default: state_allows = 1'b0;
    endcase
  end

  // Request depends on registered state only, never on tx_ready.
  assign tx_pkt_req = state_allows & (skid_cnt_q != 2'd2);
  assign pop        = tx_pkt_req & tx_pkt_rdata_vld;

  assign head     = skid_q[rd_ptr_q];
  assign tx_valid = (skid_cnt_q != 2'd0);
  assign rd       = tx_valid & tx_ready;
  assign tx_data  = head.data;
  assign tx_sop   = head.sop;
  assign tx_eop   = head.eop;
  assign tx_empty = head.empty;

  // Framing FSM and gap counter.
  always_comb begin
    // NOTE: every next-state signal takes a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    gap_d   = gap_q;
    push    = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (!in_beat.sop) begin
            err_inc = 1'b1;
          end else begin
            push = 1'b1;
            if (!in_beat.eop) begin
              state_d = ST_XFER;
            end else if (cfg_ipg_cycles != '0) begin
              state_d = ST_GAP;
              gap_d   = cfg_ipg_cycles;
            end
          end
        end
      end
      ST_XFER: begin
        if (pop) begin
          push = 1'b1;
          if (in_beat.sop) err_inc = 1'b1;
          if (in_beat.eop) begin
            if (cfg_ipg_cycles != '0) begin
              state_d = ST_GAP;
              gap_d   = cfg_ipg_cycles;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q <= IPG_W'(1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - IPG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    skid_cnt_d = skid_cnt_q;
    if (push) begin
      skid_d[wr_ptr_q] = in_beat;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (rd) rd_ptr_d = ~rd_ptr_q;
    case ({push, rd})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cfg_cnt_clr) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (rd && head.eop && !(&pkt_cnt_q)) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      if (err_inc && !(&err_cnt_q))        err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      // NOTE: the two skid entries are reset too, so tx_data/sop/eop/empty read 0 out of reset rather than X.
      skid_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      skid_cnt_q <= 2'd0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      gap_q      <= gap_d;
      skid_q     <= skid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skid_cnt_q <= skid_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign stat_pkt_cnt = pkt_cnt_q;
  assign stat_err_cnt = err_cnt_q;
  assign busy         = (state_q != ST_IDLE) | (skid_cnt_q != 2'd0);

endmodule
